// File: rtl/heston_path_sequencer.sv
// Sequences one sde_solver through an n_steps Monte-Carlo path: draws normal pairs, forms
// correlated increments, truncates S/v at zero each step and returns S_T plus call payoff.
module heston_path_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      S0,
  input  logic [31:0]      v0,
  input  logic [31:0]      K,
  input  logic [31:0]      sqrt_dt,
  input  logic [31:0]      rho,
  input  logic [31:0]      rho_c,
  input  logic [CNT_W-1:0] n_steps,
  input  logic             z_valid,
  output logic             z_ready,
  input  logic [31:0]      z1,
  input  logic [31:0]      z2,
  output logic             slv_en,
  output logic [31:0]      slv_S,
  output logic [31:0]      slv_v,
  output logic [31:0]      slv_dW1,
  output logic [31:0]      slv_dW2,
  input  logic [31:0]      slv_S_out,
  input  logic [31:0]      slv_v_out,
  output logic             busy,
  output logic [CNT_W-1:0] step_cnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      S_T,
  output logic [31:0]      payoff
);

  typedef enum logic [2:0] {IDLE, WAIT_Z, ISSUE, CAPTURE, DONE} state_t;

  state_t                 state;
  logic signed [31:0]     s_cur, v_cur, k_l, sqrt_dt_l, rho_l, rho_c_l;
  logic [CNT_W-1:0]       n_l;

  logic signed [31:0]     dw1_nxt, dw2_nxt, s_new, v_new, pay_nxt;
  logic [CNT_W-1:0]       cnt_nxt;

  // Q8.24 product: full 64-bit signed multiply, arithmetic shift, wrap to 32 bits.
  function automatic logic signed [31:0] qmul(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return 32'(p >>> 24);
  endfunction

  always_comb begin
    dw1_nxt = qmul(sqrt_dt_l, $signed(z1));
    dw2_nxt = qmul(sqrt_dt_l, qmul(rho_l, $signed(z1)) + qmul(rho_c_l, $signed(z2)));
    s_new   = ($signed(slv_S_out) < 0) ? 32'sd0 : $signed(slv_S_out);
    v_new   = ($signed(slv_v_out) < 0) ? 32'sd0 : $signed(slv_v_out);
    pay_nxt = (s_cur > k_l) ? (s_cur - k_l) : 32'sd0;
    cnt_nxt = step_cnt + CNT_W'(1);
  end

  assign z_ready = (state == WAIT_Z) && z_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s_cur     <= '0;
      v_cur     <= '0;
      k_l       <= '0;
      sqrt_dt_l <= '0;
      rho_l     <= '0;
      rho_c_l   <= '0;
      n_l       <= '0;
      slv_en    <= 1'b0;
      slv_S     <= '0;
      slv_v     <= '0;
      slv_dW1   <= '0;
      slv_dW2   <= '0;
      busy      <= 1'b0;
      step_cnt  <= '0;
      res_valid <= 1'b0;
      S_T       <= '0;
      payoff    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s_cur     <= $signed(S0);
            v_cur     <= ($signed(v0) < 0) ? 32'sd0 : $signed(v0);
            k_l       <= $signed(K);
            sqrt_dt_l <= $signed(sqrt_dt);
            rho_l     <= $signed(rho);
            rho_c_l   <= $signed(rho_c);
            n_l       <= n_steps;
            step_cnt  <= '0;
            busy      <= 1'b1;
            state     <= (n_steps == '0) ? DONE : WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (z_valid) begin
            slv_dW1 <= dw1_nxt;
            slv_dW2 <= dw2_nxt;
            slv_S   <= s_cur;
            slv_v   <= v_cur;
            slv_en  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          slv_en <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          // Solver has one cycle of latency, so its outputs belong to the step just issued.
          s_cur    <= s_new;
          v_cur    <= v_new;
          step_cnt <= cnt_nxt;
          state    <= (cnt_nxt == n_l) ? DONE : WAIT_Z;
        end
        DONE: begin
          if (!res_valid) begin
            S_T       <= s_cur;
            payoff    <= pay_nxt;
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heston_path_sequencer.sv
// Directed bench for heston_path_sequencer with a one-cycle-latency behavioural solver.
module tb_heston_path_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      S0, v0, K, sqrt_dt, rho, rho_c;
  logic [CNT_W-1:0] n_steps;
  logic             z_valid, z_ready;
  logic [31:0]      z1, z2;
  logic             slv_en;
  logic [31:0]      slv_S, slv_v, slv_dW1, slv_dW2;
  logic [31:0]      slv_S_out, slv_v_out;
  logic             busy;
  logic [CNT_W-1:0] step_cnt;
  logic             res_valid, res_ready;
  logic [31:0]      S_T, payoff;

  logic [31:0]      sigma_t;
  logic             neg_s;

  int npass = 0;
  int ntot  = 0;
  int en_cnt = 0;
  int zr_cnt = 0;
  int rv_cnt = 0;
  logic [31:0] rec_v   [0:255];
  logic [31:0] rec_dW1 [0:255];
  logic [31:0] rec_dW2 [0:255];

  heston_path_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .S0(S0), .v0(v0), .K(K),
    .sqrt_dt(sqrt_dt), .rho(rho), .rho_c(rho_c), .n_steps(n_steps),
    .z_valid(z_valid), .z_ready(z_ready), .z1(z1), .z2(z2),
    .slv_en(slv_en), .slv_S(slv_S), .slv_v(slv_v), .slv_dW1(slv_dW1), .slv_dW2(slv_dW2),
    .slv_S_out(slv_S_out), .slv_v_out(slv_v_out), .busy(busy), .step_cnt(step_cnt),
    .res_valid(res_valid), .res_ready(res_ready), .S_T(S_T), .payoff(payoff)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] qmul(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return 32'(p >>> 24);
  endfunction

  // Simplified Euler solver: S' = S + S*dW1, v' = v + sigma*dW2, optional forced negative S.
  always @(posedge clk) begin
    if (rst) begin
      slv_S_out <= '0;
      slv_v_out <= '0;
    end else if (slv_en) begin
      slv_S_out <= neg_s ? 32'hFF000000 : slv_S + qmul(slv_S, slv_dW1);
      slv_v_out <= slv_v + qmul(sigma_t, slv_dW2);
    end
  end

  always @(negedge clk) begin
    if (slv_en && en_cnt < 256) begin
      rec_v[en_cnt]   <= slv_v;
      rec_dW1[en_cnt] <= slv_dW1;
      rec_dW2[en_cnt] <= slv_dW2;
    end
    if (slv_en)    en_cnt <= en_cnt + 1;
    if (z_ready)   zr_cnt <= zr_cnt + 1;
    if (res_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else npass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] s0_i, input logic [31:0] v0_i, input logic [31:0] k_i,
                        input logic [31:0] sdt_i, input logic [31:0] r_i, input logic [31:0] rc_i,
                        input logic [CNT_W-1:0] n_i);
    S0 = s0_i; v0 = v0_i; K = k_i; sqrt_dt = sdt_i; rho = r_i; rho_c = rc_i; n_steps = n_i;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(res_valid), 32'd1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int eb, zb, rb, n;
    rst = 1'b1; start = 1'b0; z_valid = 1'b0; res_ready = 1'b0;
    z1 = '0; z2 = '0; S0 = '0; v0 = '0; K = '0; sqrt_dt = '0; rho = '0; rho_c = '0;
    n_steps = '0; sigma_t = '0; neg_s = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_rv",     32'(res_valid), 32'd0);
    chk("rst_en",     32'(slv_en), 32'd0);
    chk("rst_cnt",    32'(step_cnt), 32'd0);
    chk("rst_ST",     S_T, 32'd0);
    chk("rst_pay",    payoff, 32'd0);
    chk("rst_slv_S",  slv_S, 32'd0);
    chk("rst_dW2",    slv_dW2, 32'd0);

    // 1. Zero noise, 4 steps
    eb = en_cnt;
    z_valid = 1'b1; z1 = '0; z2 = '0;
    launch(32'h01000000, 32'h000A3D70, 32'h00800000, 32'h00800000, 32'h0, 32'h01000000, 16'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_res("t1_timeout", 100);
    chk("t1_ST",  S_T, 32'h01000000);
    chk("t1_pay", payoff, 32'h00800000);
    chk("t1_pulses", 32'(en_cnt - eb), 32'd4);
    chk("t1_cnt", 32'(step_cnt), 32'd4);
    accept();
    chk("t1_rv_drop", 32'(res_valid), 32'd0);
    chk("t1_busy_drop", 32'(busy), 32'd0);

    // 2. Correlation
    eb = en_cnt;
    z1 = 32'h01000000; z2 = 32'h02000000;
    launch(32'h01000000, 32'h000A3D70, 32'h00800000, 32'h00800000, 32'h0, 32'h01000000, 16'd1);
    wait_res("t2a_timeout", 50);
    chk("t2a_dW1", rec_dW1[eb], 32'h00800000);
    chk("t2a_dW2", rec_dW2[eb], 32'h01000000);
    chk("t2a_ST",  S_T, 32'h01800000);
    chk("t2a_pay", payoff, 32'h01000000);
    accept();
    eb = en_cnt;
    launch(32'h01000000, 32'h000A3D70, 32'h00800000, 32'h00800000, 32'h01000000, 32'h0, 16'd1);
    wait_res("t2b_timeout", 50);
    chk("t2b_dW1", rec_dW1[eb], 32'h00800000);
    chk("t2b_dW2", rec_dW2[eb], 32'h00800000);
    accept();

    // 3. n_steps = 0, z_valid held high throughout
    eb = en_cnt; zb = zr_cnt;
    z1 = '0; z2 = '0;
    launch(32'h02000000, 32'h000A3D70, 32'h03000000, 32'h00800000, 32'h0, 32'h01000000, 16'd0);
    chk("t3_rv_1cyc", 32'(res_valid), 32'd0);
    tick();
    chk("t3_rv_2cyc", 32'(res_valid), 32'd1);
    chk("t3_ST",  S_T, 32'h02000000);
    chk("t3_pay", payoff, 32'h0);
    chk("t3_no_en", 32'(en_cnt - eb), 32'd0);
    chk("t3_no_zr", 32'(zr_cnt - zb), 32'd0);
    accept();

    // 4. Stall on z_valid, then hold result with res_ready low
    z_valid = 1'b0;
    eb = en_cnt;
    launch(32'h01000000, 32'h000A3D70, 32'h02000000, 32'h00800000, 32'h0, 32'h01000000, 16'd2);
    for (int i = 0; i < 10; i++) tick();
    chk("t4_stall_en",  32'(en_cnt - eb), 32'd0);
    chk("t4_stall_cnt", 32'(step_cnt), 32'd0);
    chk("t4_stall_busy", 32'(busy), 32'd1);
    z_valid = 1'b1;
    wait_res("t4_timeout", 50);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_rv",  32'(res_valid), 32'd1);
      chk("t4_hold_ST",  S_T, 32'h01000000);
      chk("t4_hold_pay", payoff, 32'h0);
    end
    chk("t4_pulses", 32'(en_cnt - eb), 32'd2);
    accept();
    chk("t4_rv_drop", 32'(res_valid), 32'd0);

    // 5. Truncation: variance driven negative, then negative S, then negative v0
    eb = en_cnt;
    sigma_t = 32'h01000000; z1 = '0; z2 = 32'hFE000000;
    launch(32'h01000000, 32'h000A3D70, 32'h00800000, 32'h00800000, 32'h0, 32'h01000000, 16'd2);
    wait_res("t5a_timeout", 50);
    chk("t5a_v0",  rec_v[eb], 32'h000A3D70);
    chk("t5a_dW2", rec_dW2[eb], 32'hFF000000);
    chk("t5a_vtr", rec_v[eb+1], 32'h0);
    accept();
    sigma_t = '0; neg_s = 1'b1;
    launch(32'h01000000, 32'h000A3D70, 32'h00800000, 32'h00800000, 32'h0, 32'h01000000, 16'd1);
    wait_res("t5b_timeout", 50);
    chk("t5b_ST",  S_T, 32'h0);
    chk("t5b_pay", payoff, 32'h0);
    accept();
    neg_s = 1'b0;
    eb = en_cnt;
    launch(32'h01000000, 32'hFF800000, 32'h00800000, 32'h00800000, 32'h0, 32'h01000000, 16'd1);
    wait_res("t5c_timeout", 50);
    chk("t5c_v0tr", rec_v[eb], 32'h0);
    accept();

    // 6. Reset mid-path, then a clean 8-step path
    launch(32'h01800000, 32'h000A3D70, 32'h00800000, 32'h00800000, 32'h0, 32'h01000000, 16'd8);
    n = 0;
    while (step_cnt != 16'd2 && n < 100) begin
      tick();
      n++;
    end
    chk("t6_reach2", 32'(step_cnt), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cnt",  32'(step_cnt), 32'd0);
    chk("t6_en",   32'(slv_en), 32'd0);
    chk("t6_zr",   32'(z_ready), 32'd0);
    chk("t6_slvS", slv_S, 32'd0);
    rb = rv_cnt;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_no_res", 32'(rv_cnt - rb), 32'd0);
    eb = en_cnt;
    launch(32'h01800000, 32'h000A3D70, 32'h00800000, 32'h00800000, 32'h0, 32'h01000000, 16'd8);
    wait_res("t6_timeout", 200);
    chk("t6_pulses", 32'(en_cnt - eb), 32'd8);
    chk("t6_cnt8",   32'(step_cnt), 32'd8);
    chk("t6_ST",     S_T, 32'h01800000);
    chk("t6_pay",    payoff, 32'h01000000);
    accept();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
